serial_alu16_seq: RTL and testbench

SERIAL_ALU16_SEQ -- requirements
Module: serial_alu16_seq

---
 rtl/serial_alu_pkg.sv | 18 +
 rtl/serial_alu16_seq_slice.sv | 40 ++++
 rtl/serial_alu16_seq.sv | 153 +++++++++++++++
 tb/tb_serial_alu16_seq.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_alu_pkg.sv
// Shared types and constants for the nibble-serial 16-bit ALU.
package serial_alu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_NIB  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b110;
   localparam logic [2:0] OP_SLT = 3'b111;

   localparam int NIBBLES = 4;

endpackage

// File: rtl/serial_alu16_seq_slice.sv
// Combinational 4-bit ALU slice: AND/OR/ADD/less-pass with optional B inversion.
module FourBitALU
   import serial_alu_pkg::*;
(
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       binv,
   input  logic [1:0] sel,
   input  logic       cin,
   input  logic       less,
   output logic [3:0] y,
   output logic       cout,
   output logic       overflow,
   output logic       set,
   output logic       zero
);

   logic [3:0] b_eff;
   logic [4:0] sum;

   assign b_eff = binv ? ~b : b;
   assign sum   = {1'b0, a} + {1'b0, b_eff} + {4'b0000, cin};

   always_comb begin
      y = 4'h0;
      case (sel)
         2'b00:   y = a & b_eff;
         2'b01:   y = a | b_eff;
         2'b10:   y = sum[3:0];
         default: y = {3'b000, less};
      endcase
   end

   assign cout     = sum[4];
   assign set      = sum[3];
   // Signed overflow: operands agree in sign but the sum does not.
   assign overflow = (a[3] == b_eff[3]) && (sum[3] != a[3]);
   assign zero     = (y == 4'h0);

endmodule

// File: rtl/serial_alu16_seq.sv
// 16-bit ALU evaluated one nibble per cycle through a single 4-bit slice.
// Optional macro SLT_OVF_CORRECT_EN: SLT corrects the sign bit with nibble-3 overflow.
module serial_alu16_seq
   import serial_alu_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic [2:0]  op,
   output logic        busy,
   output logic        done,
   output logic [15:0] result,
   output logic        cout,
   output logic        overflow,
   output logic        zero
);

   state_e      state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic        carry_q, carry_d;
   logic [15:0] a_q, a_d;
   logic [15:0] b_q, b_d;
   logic [2:0]  op_q, op_d;
   logic [11:0] acc_q, acc_d;
   logic        zacc_q, zacc_d;
   logic [15:0] result_q, result_d;
   logic        cout_q, cout_d;
   logic        ovf_q, ovf_d;
   logic        zero_q, zero_d;
   logic        done_q, done_d;

   logic [3:0]  slice_a, slice_b, slice_y;
   logic        slice_cout, slice_ovf, slice_set, slice_zero;
   logic        lt;
   logic        is_slt;

   assign slice_a = a_q[{cnt_q, 2'b00} +: 4];
   assign slice_b = b_q[{cnt_q, 2'b00} +: 4];

   FourBitALU u_slice (
      .a        (slice_a),
      .b        (slice_b),
      .binv     (op_q[2]),
      .sel      (op_q[1:0]),
      .cin      (carry_q),
      .less     (1'b0),
      .y        (slice_y),
      .cout     (slice_cout),
      .overflow (slice_ovf),
      .set      (slice_set),
      .zero     (slice_zero)
   );

   assign is_slt = (op_q == OP_SLT);

`ifdef SLT_OVF_CORRECT_EN
   assign lt = slice_set ^ slice_ovf;
`else
   assign lt = slice_set;
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      carry_d  = carry_q;
      a_d      = a_q;
      b_d      = b_q;
      op_d     = op_q;
      acc_d    = acc_q;
      zacc_d   = zacc_q;
      result_d = result_q;
      cout_d   = cout_q;
      ovf_d    = ovf_q;
      zero_d   = zero_q;
      done_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_NIB;
               cnt_d   = 2'd0;
               carry_d = op[2];
               a_d     = a;
               b_d     = b;
               op_d    = op;
               zacc_d  = 1'b1;
            end
         end
         ST_NIB: begin
            carry_d = slice_cout;
            cnt_d   = cnt_q + 2'd1;
            zacc_d  = zacc_q & slice_zero;
            for (int i = 0; i < NIBBLES - 1; i++) begin
               if (cnt_q == 2'(i)) acc_d[i*4 +: 4] = slice_y;
            end
            // Last nibble: commit everything straight from the slice outputs.
            if (cnt_q == 2'(NIBBLES - 1)) begin
               state_d  = ST_DONE;
               result_d = is_slt ? {15'b0, lt} : {slice_y, acc_q};
               cout_d   = slice_cout;
               ovf_d    = slice_ovf;
               zero_d   = is_slt ? ~lt : (zacc_q & slice_zero);
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= 2'd0;
         carry_q  <= 1'b0;
         a_q      <= 16'h0000;
         b_q      <= 16'h0000;
         op_q     <= 3'b000;
         acc_q    <= 12'h000;
         zacc_q   <= 1'b1;
         result_q <= 16'h0000;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
         zero_q   <= 1'b1;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         carry_q  <= carry_d;
         a_q      <= a_d;
         b_q      <= b_d;
         op_q     <= op_d;
         acc_q    <= acc_d;
         zacc_q   <= zacc_d;
         result_q <= result_d;
         cout_q   <= cout_d;
         ovf_q    <= ovf_d;
         zero_q   <= zero_d;
         done_q   <= done_d;
      end
   end

   assign busy     = (state_q == ST_NIB);
   assign done     = done_q;
   assign result   = result_q;
   assign cout     = cout_q;
   assign overflow = ovf_q;
   assign zero     = zero_q;

endmodule

// File: tb/tb_serial_alu16_seq.sv
// Scoreboard bench for serial_alu16_seq: directed corner cases plus random ops vs. an arithmetic model.
module tb_serial_alu16_seq;
   import serial_alu_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [15:0] a_in, b_in;
   logic [2:0]  op_in;
   logic        busy, done;
   logic [15:0] result;
   logic        cout, overflow, zero;

   serial_alu16_seq dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .a        (a_in),
      .b        (b_in),
      .op       (op_in),
      .busy     (busy),
      .done     (done),
      .result   (result),
      .cout     (cout),
      .overflow (overflow),
      .zero     (zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] res;
      logic        co;
      logic        ov;
      logic        z;
      bit          arith;
      int          acc_cyc;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   int   busy_run = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, expv);
      end
   endtask

   function automatic exp_t model(input logic [15:0] av, input logic [15:0] bv, input logic [2:0] opv);
      exp_t e;
      int sa, sb, ua, ub, d, sd;
      bit lt;
      sa = $signed(av);
      sb = $signed(bv);
      ua = av;
      ub = bv;
      e.res = 16'h0; e.co = 1'b0; e.ov = 1'b0; e.arith = 1'b0; e.acc_cyc = 0;
      case (opv)
         OP_AND: e.res = av & bv;
         OP_OR:  e.res = av | bv;
         OP_ADD: begin
            d = ua + ub;
            sd = sa + sb;
            e.res = d[15:0];
            e.co = (d > 65535);
            e.ov = (sd > 32767) || (sd < -32768);
            e.arith = 1'b1;
         end
         OP_SUB: begin
            d = ua - ub;
            sd = sa - sb;
            e.res = d[15:0];
            e.co = (ua >= ub);
            e.ov = (sd > 32767) || (sd < -32768);
            e.arith = 1'b1;
         end
         default: begin
`ifdef SLT_OVF_CORRECT_EN
            lt = (sa < sb);
`else
            d = ua - ub;
            lt = d[15];
`endif
            e.res = {15'b0, lt};
         end
      endcase
      e.z = (e.res == 16'h0);
      return e;
   endfunction

   // Monitor: pops one expectation per done pulse.
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         busy_run = 0;
      end else begin
         if (busy && done) check("busy_with_done", 1, 0);
         if (busy) busy_run++;
         if (done) begin
            if (exp_q.size() == 0) begin
               check("unexpected_done", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("result", result, e.res);
               check("zero", zero, e.z);
               if (e.arith) begin
                  check("cout", cout, e.co);
                  check("overflow", overflow, e.ov);
               end
               check("latency", cyc - e.acc_cyc, 5);
               check("busy_cycles", busy_run, 4);
               $display("txn done: result=%h cout=%b ovf=%b zero=%b", result, cout, overflow, zero);
            end
            busy_run = 0;
         end
      end
   end

   task automatic issue(input logic [15:0] av, input logic [15:0] bv, input logic [2:0] opv, input bit push);
      exp_t e;
      @(negedge clk);
      a_in = av; b_in = bv; op_in = opv; start = 1'b1;
      @(posedge clk);
      #1;
      if (push) begin
         e = model(av, bv, opv);
         e.acc_cyc = cyc;
         exp_q.push_back(e);
      end
      @(negedge clk);
      start = 1'b0;
      a_in = 16'($urandom);
      b_in = 16'($urandom);
      op_in = 3'($urandom);
   endtask

   task automatic wait_done();
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      if (!seen) check("done_timeout", 0, 1);
   endtask

   task automatic run_op(input logic [15:0] av, input logic [15:0] bv, input logic [2:0] opv);
      issue(av, bv, opv, 1'b1);
      wait_done();
   endtask

   logic [2:0] ops [5];
   logic [15:0] corner [4];

   initial begin
      ops[0] = OP_AND; ops[1] = OP_OR; ops[2] = OP_ADD; ops[3] = OP_SUB; ops[4] = OP_SLT;
      corner[0] = 16'h8000; corner[1] = 16'h7FFF; corner[2] = 16'hFFFF; corner[3] = 16'h0000;
      rst_n = 1'b0; start = 1'b0; a_in = 16'h0; b_in = 16'h0; op_in = 3'b000;
      #200_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #1;
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_result", result, 0);
      check("rst_cout", cout, 0);
      check("rst_ovf", overflow, 0);
      check("rst_zero", zero, 1);
      rst_n = 1'b1;

      run_op(16'h0FFF, 16'h0001, OP_ADD);
      run_op(16'h8000, 16'h8000, OP_SUB);
      run_op(16'h7FFF, 16'hFFFF, OP_SUB);
      run_op(16'h8000, 16'h0001, OP_SLT);

      // Starts during busy must be dropped.
      issue(16'h0001, 16'h0002, OP_ADD, 1'b1);
      a_in = 16'h0005; b_in = 16'h0005; start = 1'b1;
      repeat (4) @(negedge clk);
      start = 1'b0;
      wait_done();
      repeat (3) @(negedge clk);
      check("busy_reject_queue", exp_q.size(), 0);

      // Reset on the second NIB cycle aborts without done.
      run_op(16'h1234, 16'h1111, OP_ADD);
      issue(16'h4444, 16'h1111, OP_ADD, 1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_result", result, 0);
      check("abort_zero", zero, 1);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      run_op(16'h0010, 16'h0020, OP_ADD);

      run_op(16'hF0F0, 16'h3C3C, OP_AND);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         a_in = 16'($urandom); b_in = 16'($urandom);
         check("hold_result", result, 16'h3030);
      end
      run_op(16'hF0F0, 16'h3C3C, OP_OR);

      for (int n = 0; n < 40; n++) begin
         logic [15:0] ra, rb;
         ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : 16'($urandom);
         rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : 16'($urandom);
         run_op(ra, rb, ops[$urandom_range(0, 4)]);
      end

      repeat (4) @(negedge clk);
      check("queue_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
